sntc_ldpc_cword_serializer: RTL
===============================

Name: sntc_ldpc_cword_serializer

Overview:
- Downstream of the LDPC encoder wrapper. Captures each NN-bit encoded codeword together with the wrapper's syndrome-check result.
- Streams the codeword out in W-bit beats over a valid/ready interface toward the channel/transmit side.
- Holds a one-codeword pending buffer so the encoder can deliver the next codeword while the current one is still streaming.
- Keeps saturating counters of codewords sent and codewords that failed the syndrome check.

Parameters:
- NN, 'h000d0, codeword length in bits (matches encoder NN).
- W, 16, output beat width in bits, 1 <= W <= NN.
- NBEATS, (NN+W-1)/W, beats per codeword (derived; 13 at defaults).
- BC_W, $clog2(NBEATS), beat counter width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rstn, input, 1, asynchronous active-high reset (asserted = 1).
- clr, input, 1, synchronous clear; same effect as reset, evaluated at a clock edge.
- cw_in, input, NN, encoded codeword (encoder y_nr_enc).
- cw_ok_in, input, 1, syndrome-zero flag for cw_in (encoder valid_cword_enc).
- cw_valid_in, input, 1, cw_in/cw_ok_in are valid this cycle.
- cw_ready_out, output, 1, serializer can accept a codeword.
- dout, output, W, current beat.
- dout_valid, output, 1, dout is valid.
- dout_ready, input, 1, sink accepts the beat.
- dout_last, output, 1, current beat is beat NBEATS-1.
- dout_err, output, 1, the codeword being streamed had cw_ok_in=0 at capture; constant for all of its beats.
- busy, output, 1, state is STREAM or the pending buffer is full.
- cw_sent_cnt, output, CNT_W, codewords fully streamed; saturates at all-ones.
- cw_err_cnt, output, CNT_W, captured codewords with cw_ok_in=0; saturates at all-ones.

Behaviour:
- Reset / clr:
  - Reset state: IDLE, beat_cnt=0, pending empty.
  - Outputs at reset: dout=0, dout_valid=0, dout_last=0, dout_err=0, busy=0, cw_sent_cnt=0, cw_err_cnt=0, cw_ready_out=1.
  - Reset or clr mid-stream discards the active and the pending codeword; no partial-beat completion.
  - clr has priority over every other event in the same cycle.
- Registers:
  - Active shift register sh[NN-1:0] plus sh_err.
  - Pending register pd[NN-1:0] plus pd_err and pd_full.
- Accept rule: cw_ready_out = !pd_full (combinational from state only). A capture occurs when cw_valid_in && cw_ready_out.
- Capture routing:
  - IDLE: capture goes to sh; next cycle the state is STREAM and dout_valid=1. Capture-to-first-beat latency is 1 cycle.
  - STREAM, last beat accepted this cycle, pd empty: capture goes directly into sh; no bubble.
  - STREAM, any other cycle: capture goes to pd; pd_full=1.
- Beat mapping:
  - dout = sh[beat_cnt*W +: W], beat 0 = cw bits [W-1:0] (LSB first).
  - Bits beyond NN-1 in the final beat are driven 0.
- Beat handshake:
  - A beat transfers when dout_valid && dout_ready.
  - While dout_valid=1 and dout_ready=0, dout, dout_last and dout_err hold stable.
  - dout_valid never drops without a transfer, except on reset/clr.
- FSM IDLE -> STREAM: on capture.
- FSM STREAM, beat transfer with beat_cnt < NBEATS-1: beat_cnt increments.
- FSM STREAM, beat transfer with beat_cnt = NBEATS-1 (last beat):
  - cw_sent_cnt increments (saturating) and beat_cnt returns to 0.
  - If pd_full: pd moves to sh, pd_full=0, state stays STREAM. Back-to-back, no idle cycle.
  - Else if a capture occurs this cycle: it loads sh, state stays STREAM.
  - Else: state goes to IDLE and dout_valid=0 next cycle.
- Last-beat flag: dout_last = dout_valid && beat_cnt == NBEATS-1.
- Error counter:
  - cw_err_cnt increments (saturating) at capture time when cw_ok_in=0.
  - The codeword is still streamed, with dout_err=1.
- Simultaneous capture and pd->sh transfer: impossible, because cw_ready_out=0 whenever pd_full.
- NBEATS=1: every beat is last; same rules apply.

Test Plan:
- Single codeword, NN=208, W=16, cw_in=208'h1 followed by ascending bytes, dout_ready=1 -> 13 consecutive beats starting the cycle after capture; beat0=cw[15:0]; dout_last only on beat 12; cw_sent_cnt=1; then IDLE with dout_valid=0.
- Back-to-back: second codeword offered during beat 3 of the first -> cw_ready_out falls to 0 the next cycle; 26 beats with no gap; cw_ready_out returns to 1 after beat 12 transfers; cw_sent_cnt=2.
- Backpressure: dout_ready toggles 1,0,0,1 repeatedly -> dout and dout_last are stable across stalls; beat order is unchanged; total of 13 transfers.
- Error tag: capture with cw_ok_in=0 -> dout_err=1 on all 13 beats; cw_err_cnt=1; the following codeword with cw_ok_in=1 has dout_err=0.
- Padding: W=32 -> NBEATS=7; beat 6 = {16'h0, cw[207:192]}.
- Reset/clr mid-stream: assert rstn at beat 5 while pd_full -> outputs go to reset values immediately (asynchronously), pd is discarded, and the next capture streams from beat 0. Repeat with clr -> same effect at the next clock edge; counters are 0.

Source files
------------

// File: rtl/sntc_ldpc_cword_serializer.sv
// Serializes each LDPC codeword into W-bit beats (LSB first), one codeword buffered behind the active one.
// Capture-to-first-beat latency 1 cycle; back-to-back codewords stream with no gap; dout holds while dout_ready=0.
module sntc_ldpc_cword_serializer #(
    parameter int NN     = 'h000d0,
    parameter int W      = 16,
    parameter int NBEATS = (NN + W - 1) / W,
    parameter int BC_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [NN-1:0]    cw_in,
    input  logic             cw_ok_in,
    input  logic             cw_valid_in,
    output logic             cw_ready_out,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             dout_err,
    output logic             busy,
    output logic [CNT_W-1:0] cw_sent_cnt,
    output logic [CNT_W-1:0] cw_err_cnt
);

    localparam int              SW        = NBEATS * W;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(NBEATS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state_q, state_d;
    logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]    sh_q, sh_d;
    logic             sh_err_q, sh_err_d;
    logic [NN-1:0]    pd_q, pd_d;
    logic             pd_err_q, pd_err_d;
    logic             pd_full_q, pd_full_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic capture;
    logic beat_xfer;
    logic last_xfer;

    // Zero-extension supplies the padding bits of the final beat.
    function automatic logic [SW-1:0] pad_cw(input logic [NN-1:0] cw);
        pad_cw = SW'(cw);
    endfunction

    assign cw_ready_out = !pd_full_q;
    assign capture      = cw_valid_in && !pd_full_q;
    assign dout_valid   = (state_q == STREAM);
    assign beat_xfer    = dout_valid && dout_ready;
    assign last_xfer    = beat_xfer && (beat_cnt_q == LAST_BEAT);
    assign dout         = dout_valid ? sh_q[W-1:0] : '0;
    assign dout_last    = dout_valid && (beat_cnt_q == LAST_BEAT);
    assign dout_err     = dout_valid && sh_err_q;
    assign busy         = dout_valid || pd_full_q;
    assign cw_sent_cnt  = sent_cnt_q;
    assign cw_err_cnt   = err_cnt_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        sh_d       = sh_q;
        sh_err_d   = sh_err_q;
        pd_d       = pd_q;
        pd_err_d   = pd_err_q;
        pd_full_d  = pd_full_q;
        sent_cnt_d = sent_cnt_q;
        err_cnt_d  = err_cnt_q;

        if (capture && !cw_ok_in && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (capture) begin
                    sh_d       = pad_cw(cw_in);
                    sh_err_d   = !cw_ok_in;
                    beat_cnt_d = '0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (last_xfer) begin
                    beat_cnt_d = '0;
                    if (sent_cnt_q != '1) begin
                        sent_cnt_d = sent_cnt_q + CNT_W'(1);
                    end
                    // A pending codeword always wins; capture cannot coincide with pd_full.
                    if (pd_full_q) begin
                        sh_d      = pad_cw(pd_q);
                        sh_err_d  = pd_err_q;
                        pd_full_d = 1'b0;
                    end else if (capture) begin
                        sh_d     = pad_cw(cw_in);
                        sh_err_d = !cw_ok_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat_xfer) begin
                    beat_cnt_d = beat_cnt_q + BC_W'(1);
                    sh_d       = sh_q >> W;
                end
                if (capture && !last_xfer) begin
                    pd_d      = cw_in;
                    pd_err_d  = !cw_ok_in;
                    pd_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            sh_q       <= '0;
            sh_err_q   <= 1'b0;
            pd_q       <= '0;
            pd_err_q   <= 1'b0;
            pd_full_q  <= 1'b0;
            sent_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (clr) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            sh_q       <= '0;
            sh_err_q   <= 1'b0;
            pd_q       <= '0;
            pd_err_q   <= 1'b0;
            pd_full_q  <= 1'b0;
            sent_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            sh_q       <= sh_d;
            sh_err_q   <= sh_err_d;
            pd_q       <= pd_d;
            pd_err_q   <= pd_err_d;
            pd_full_q  <= pd_full_d;
            sent_cnt_q <= sent_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule
